// File: rtl/maf_lzd_pkg.sv
// maf_lzd_pkg
// Shared constants and types for the MAF LZD add/count pipeline.
//   - W, LANE_W        : datapath width and dual-mode lane width
//   - GUARD_HI/LO      : guard field between the lanes in dual mode
//   - HALF_LO          : number of ignored low bits in half mode
//   - CONT_*           : operating mode encodings carried on 'cont'
//   - s1_payload_t     : contents of the first pipeline register
package maf_lzd_pkg;

    localparam int W        = 56;
    localparam int LANE_W   = 24;
    localparam int GUARD_HI = 31;
    localparam int GUARD_LO = 24;
    localparam int HALF_LO  = 8;

    localparam logic [2:0] CONT_SINGLE = 3'b000;
    localparam logic [2:0] CONT_DUAL   = 3'b001;
    localparam logic [2:0] CONT_HALF   = 3'b010;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [2:0]   cont;
        logic         d_pos;
    } s1_payload_t;

endpackage

// File: rtl/maf_lzc.sv
// maf_lzc
// Combinational leading-zero counter with an all-zero flag.
//   val  : field to count (MSB is counted first)
//   cnt  : number of leading zeros; equals WIDTH when val is all zero
//   zero : 1 when val is all zero
module maf_lzc
    import maf_lzd_pkg::*;
#(
    parameter int WIDTH = 56,
    parameter int CW    = 6
) (
    input  logic [WIDTH-1:0] val,
    output logic [CW-1:0]    cnt,
    output logic             zero
);

    // Scan from the LSB upward so the last set bit seen (the highest one)
    // determines the count; with no set bit the count saturates at WIDTH.
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (val[i]) begin
                cnt = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign zero = (val == '0);

endmodule

// File: rtl/maf_lzd_add_pipe.sv
// maf_lzd_add_pipe
// Two-stage operand-select / add / leading-zero-count stage of the MAF
// datapath. Stage 1 picks the d>0 or d<=0 operand pair and adds it; stage 2
// counts leading zeros of the sum according to the mode on 'cont'.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   cont, d_pos           : mode and pair select, sampled on accept
//   num_p_0/1, num_n_0/1  : d>0 and d<=0 operand pairs
//   out_valid / out_ready : downstream handshake
//   sum                   : registered 56-bit sum (0 for unsupported modes)
//   lz_hi, zero_hi        : count / zero flag of the primary or high lane
//   lz_lo, zero_lo        : count / zero flag of the low lane (dual only)
//   mode_err              : unsupported mode seen for this result
// Build option: define MAF_LZD_DUAL_EN to enable dual-lane mode (cont=001);
// without it cont=001 reports mode_err and the low-lane counter is absent.
module maf_lzd_add_pipe #(
    parameter int W      = maf_lzd_pkg::W,
    parameter int LANE_W = maf_lzd_pkg::LANE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   cont,
    input  logic         d_pos,
    input  logic [W-1:0] num_p_0,
    input  logic [W-1:0] num_p_1,
    input  logic [W-1:0] num_n_0,
    input  logic [W-1:0] num_n_1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic [5:0]   lz_hi,
    output logic [4:0]   lz_lo,
    output logic         zero_hi,
    output logic         zero_lo,
    output logic         mode_err
);

    import maf_lzd_pkg::*;

    logic         s1_v;
    logic         s2_v;
    logic         s2_adv;
    logic         accept;
    logic [W-1:0] op0;
    logic [W-1:0] op1;
    s1_payload_t  s1_q;

    logic [W-1:0] hi_field;
    logic [5:0]   hi_w;
    logic [5:0]   hi_cnt;
    logic         hi_zero;
    logic         mode_ok;
    logic [4:0]   lo_cnt_eff;
    logic         lo_zero_eff;

    // Each stage advances when it is empty or its successor takes its data,
    // so a full pipe still accepts in the same cycle the output drains.
    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;

    assign op0 = d_pos ? num_p_0 : num_n_0;
    assign op1 = d_pos ? num_p_1 : num_n_1;

    // Stage 1: capture the sum of the selected pair. The carry-out is
    // dropped; in dual mode the zero guard byte absorbs the low-lane carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (accept) begin
                s1_q.sum   <= op0 + op1;
                s1_q.cont  <= cont;
                s1_q.d_pos <= d_pos;
            end
        end
    end

    // Build the field for the primary counter. Ignored low bits are zeroed so
    // one 56-bit counter serves every mode; an all-zero field is then replaced
    // by its own width, since the counter itself would report 56.
    always_comb begin
        hi_field = '0;
        hi_w     = 6'(W);
        mode_ok  = 1'b1;
        case (s1_q.cont)
            CONT_SINGLE: begin
                hi_field = s1_q.sum;
            end
            CONT_HALF: begin
                hi_field = {s1_q.sum[W-1:HALF_LO], {HALF_LO{1'b0}}};
                hi_w     = 6'(W - HALF_LO);
            end
`ifdef MAF_LZD_DUAL_EN
            CONT_DUAL: begin
                hi_field = {s1_q.sum[W-1:GUARD_HI+1], {(GUARD_HI+1){1'b0}}};
                hi_w     = 6'(LANE_W);
            end
`endif
            default: begin
                mode_ok = 1'b0;
            end
        endcase
    end

    maf_lzc #(.WIDTH(W), .CW(6)) u_lzc_hi (
        .val  (hi_field),
        .cnt  (hi_cnt),
        .zero (hi_zero)
    );

`ifdef MAF_LZD_DUAL_EN
    logic [4:0] lo_cnt;
    logic       lo_zero;

    maf_lzc #(.WIDTH(LANE_W), .CW(5)) u_lzc_lo (
        .val  (s1_q.sum[GUARD_LO-1:0]),
        .cnt  (lo_cnt),
        .zero (lo_zero)
    );

    assign lo_cnt_eff  = (s1_q.cont == CONT_DUAL) ? lo_cnt : 5'd0;
    assign lo_zero_eff = (s1_q.cont == CONT_DUAL) && lo_zero;
`else
    assign lo_cnt_eff  = 5'd0;
    assign lo_zero_eff = 1'b0;
`endif

    // Stage 2: register the counts. The output register only loads when the
    // stage advances, so results hold steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            sum      <= '0;
            lz_hi    <= '0;
            lz_lo    <= '0;
            zero_hi  <= 1'b0;
            zero_lo  <= 1'b0;
            mode_err <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                if (mode_ok) begin
                    sum      <= s1_q.sum;
                    lz_hi    <= hi_zero ? hi_w : hi_cnt;
                    lz_lo    <= lo_cnt_eff;
                    zero_hi  <= hi_zero;
                    zero_lo  <= lo_zero_eff;
                    mode_err <= 1'b0;
                end else begin
                    sum      <= '0;
                    lz_hi    <= '0;
                    lz_lo    <= '0;
                    zero_hi  <= 1'b0;
                    zero_lo  <= 1'b0;
                    mode_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/maf_lzd_add_pipe.md
# maf_lzd_add_pipe

Two-stage pipelined operand-select, add and leading-zero-count stage of the MAF datapath. It sits directly downstream of the operand generator in the LZD section. It takes both operand pairs from that generator (the d>0 pair and the d<=0 pair) together with the alignment-sign decision. It produces the raw 56-bit sum plus per-lane leading-zero counts for the normalisation shifter, with a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 56, datapath width; fixed by the operand format and not to be overridden.
- LANE_W, 24, width of each lane in dual mode.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block accepts this cycle.
- cont  in  3  mode: 000 single, 001 dual, 010 half; others unsupported.
- d_pos  in  1  1 selects the d>0 pair, 0 selects the d<=0 pair.
- num_p_0, num_p_1  in  56  d>0 operands.
- num_n_0, num_n_1  in  56  d<=0 operands.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts.
- sum  out  56  registered sum.
- lz_hi  out  6  leading zeros of the primary or high lane.
- lz_lo  out  5  leading zeros of the low lane (dual mode only, else 0).
- zero_hi, zero_lo  out  1  lane all-zero flags.
- mode_err  out  1  unsupported cont seen for this result.

## Operation
- Stage 1 (S1), on accept:
  - Select the pair: d_pos ? {num_p_0, num_p_1} : {num_n_0, num_n_1}.
  - sum1 = op0 + op1 mod 2^56; the carry-out is discarded.
  - Register sum1, cont and d_pos.
  - In dual mode, bits [31:24] are zero in both operands and act as a guard, so a low-lane carry lands in bit 24 and never reaches the high lane.
- Stage 2 (S2): count leading zeros on the S1 register.
  - cont=000: lz_hi = clz(sum[55:0]), range 0..56; lz_lo=0; zero_lo=0.
  - cont=010: lz_hi = clz(sum[55:8]), range 0..48; bits [7:0] are ignored.
  - cont=001: lz_hi = clz(sum[55:32]), range 0..24; lz_lo = clz(sum[23:0]), range 0..24; guard bits [31:24] are ignored for both counts.
  - Unsupported cont: sum=0, lz_hi=0, lz_lo=0, zero flags 0, mode_err=1.
  - zero_x=1 exactly when the counted field is all zero; lz_x then equals the field width.
- Handshake:
  - Transfer occurs when valid&&ready.
  - Each stage holds a valid bit and advances when empty or when its successor accepts.
  - in_ready = !s1_v || (!s2_v || out_ready).
  - Outputs stay stable while out_valid && !out_ready.

## Timing
- Latency 2 cycles, accept to out_valid; throughput 1 per cycle with out_ready high.
- Accept and drain in the same cycle are legal at both stages; there is no bubble.
- Full condition: both stages valid and out_ready=0, giving in_ready=0. Capacity is 2 entries; order is preserved.
- Empty condition: in_ready=1 and out_valid=0.
- Reset values: out_valid=0, sum=0, lz_hi=0, lz_lo=0, zero_hi=0, zero_lo=0, mode_err=0. Internal valid bits are 0.
- Reset asserted mid-operation discards in-flight entries immediately; nothing is emitted after release until a new accept.
- Inputs are sampled only on accept; input changes while in_ready=0 have no effect.

## Configuration
- MAF_LZD_DUAL_EN defined: cont=001 is handled as the dual-lane mode above.
- MAF_LZD_DUAL_EN undefined:
  - cont=001 is treated as unsupported (mode_err=1).
  - lz_lo and zero_lo are tied to 0 and the low-lane counter is not instantiated.
  - Port list is unchanged.

## Structure
- Package maf_lzd_pkg holds:
  - CONT_SINGLE=3'b000, CONT_DUAL=3'b001, CONT_HALF=3'b010.
  - W, LANE_W and the guard-field bounds (31:24).
  - The S1 payload struct (sum, cont, d_pos).
- Sub-module maf_lzc: parameterised-width combinational leading-zero counter with a zero flag. Instantiated once for the high/primary field (muxed by mode) and once for the low lane.

## Test plan
- Single mode: cont=000, d_pos=1, num_p_0=num_p_1=56'h00000000000100 → after 2 cycles sum=56'h00000000000200, lz_hi=46, zero_hi=0.
- Dual mode: cont=001, d_pos=0, num_n_0=56'h000001_00_800000, num_n_1=56'h000000_00_800000 → sum=56'h000001_01_000000, lz_hi=23, lz_lo=24, zero_lo=1.
- Half mode and unsupported mode, back-to-back:
  - cont=010 with op0=56'h80000000000000, op1=0 → lz_hi=0.
  - Next cycle cont=111 → mode_err=1 and sum=0.
- Backpressure: out_ready=0 while 3 inputs are offered → in_ready drops after 2 accepts. Release out_ready → results emerge in order with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with both stages valid → out_valid=0 and all outputs 0 asynchronously. After release, first out_valid comes exactly 2 cycles after the next accept.
